axi_copy_master: RTL and testbench

// - AXI master copy engine: the initiator that drives the AXI_SLAVE memory model and real slaves.
// - Reads a contiguous region with INCR read bursts, buffers each burst, then writes it with INCR write bursts.
// - Core data mover beneath the scatter-gather descriptor engine; exercises all five AXI channels as master.

---
 rtl/dma_pkg.sv | 9 +
 rtl/dma_burst_fifo.sv | 47 ++++
 rtl/axi_copy_master.sv | 173 +++++++++++++++++
 tb/tb_axi_copy_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// dma_pkg: shared FSM states, AXI encodings and the beat-size helper for the copy engine
package dma_pkg;
    typedef enum logic [2:0] {S_IDLE, S_RREQ, S_RDATA, S_WREQ, S_WDATA, S_WRESP} state_e;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    function automatic logic [2:0] axi_size(input int bytes_per_beat);
        return 3'($clog2(bytes_per_beat));
    endfunction
endpackage

// File: rtl/dma_burst_fifo.sv
// dma_burst_fifo: synchronous FIFO holding one read burst until it is written back out
module dma_burst_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    level_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic push_ok, pop_ok;
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign push_ok = push_i && !full_o;
    assign pop_ok = pop_i && !empty_o;
    assign full_o = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign level_o = cnt_q;
    assign dout_o = mem_q[rd_q];
    // storage array, written on every accepted push
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end
    // read/write pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= nxt(wr_q);
            if (pop_ok) rd_q <= nxt(rd_q);
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/axi_copy_master.sv
// axi_copy_master: AXI master that copies a region burst by burst (read into buffer, then write out)
module axi_copy_master
    import dma_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH = 4,
    parameter int AXI_ID = 0,
    parameter int MAX_BURST = 16,
    parameter int LEN_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [LEN_WIDTH-1:0]    byte_len,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ID_WIDTH-1:0]     wid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);
    localparam int BPB = DATA_WIDTH / 8;
    localparam int SZ = $clog2(BPB);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int CW = $clog2(MAX_BURST + 1);
    state_e state_q;
    logic [ADDR_WIDTH-1:0] src_q, dst_q, step;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [BW-1:0] beats_q;
    logic busy_q, done_q, err_q, arvalid_q, rready_q, awvalid_q, bready_q;
    logic full, empty;
    logic [CW-1:0] level;
    logic unused_ok;
    function automatic logic [BW-1:0] burst_of(input logic [LEN_WIDTH-1:0] r);
        return (r > LEN_WIDTH'(MAX_BURST)) ? BW'(MAX_BURST) : r[BW-1:0];
    endfunction
    assign unused_ok = ^{rid, bid, full};
    assign rem_d = rem_q - LEN_WIDTH'(beats_q);
    assign step = ADDR_WIDTH'(beats_q) << SZ;
    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
    assign arid = ID_WIDTH'(AXI_ID);
    assign araddr = src_q;
    assign arlen = 4'(beats_q - 1'b1);
    assign arsize = axi_size(BPB);
    assign arburst = AXI_BURST_INCR;
    assign arvalid = arvalid_q;
    assign rready = rready_q;
    assign awid = ID_WIDTH'(AXI_ID);
    assign awaddr = dst_q;
    assign awlen = 4'(beats_q - 1'b1);
    assign awsize = axi_size(BPB);
    assign awburst = AXI_BURST_INCR;
    assign awvalid = awvalid_q;
    assign wid = ID_WIDTH'(AXI_ID);
    assign wstrb = '1;
    assign wvalid = (state_q == S_WDATA) && !empty;
    assign wlast = wvalid && (level == CW'(1));
    assign bready = bready_q;
    dma_burst_fifo #(.DEPTH(MAX_BURST), .WIDTH(DATA_WIDTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push_i(rready_q && rvalid),
        .din_i(rdata),
        .pop_i(wvalid && wready),
        .dout_o(wdata),
        .full_o(full),
        .empty_o(empty),
        .level_o(level)
    );
    // copy sequencer: one burst read, buffered, written and acknowledged before the next
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            src_q <= '0;
            dst_q <= '0;
            rem_q <= '0;
            beats_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q <= 1'b0;
            awvalid_q <= 1'b0;
            bready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    err_q <= 1'b0;
                    if (byte_len != '0) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        rem_q <= byte_len >> SZ;
                        beats_q <= burst_of(byte_len >> SZ);
                        arvalid_q <= 1'b1;
                        busy_q <= 1'b1;
                        state_q <= S_RREQ;
                    end else done_q <= 1'b1;
                end
                S_RREQ: if (arready) begin
                    arvalid_q <= 1'b0;
                    rready_q <= 1'b1;
                    state_q <= S_RDATA;
                end
                S_RDATA: if (rvalid) begin
                    if (rresp != AXI_RESP_OKAY) err_q <= 1'b1;
                    if (rlast) begin
                        rready_q <= 1'b0;
                        awvalid_q <= 1'b1;
                        state_q <= S_WREQ;
                    end
                end
                S_WREQ: if (awready) begin
                    awvalid_q <= 1'b0;
                    state_q <= S_WDATA;
                end
                S_WDATA: if (wvalid && wready && wlast) begin
                    bready_q <= 1'b1;
                    state_q <= S_WRESP;
                end
                S_WRESP: if (bvalid) begin
                    bready_q <= 1'b0;
                    if (bresp != AXI_RESP_OKAY) err_q <= 1'b1;
                    src_q <= src_q + step;
                    dst_q <= dst_q + step;
                    rem_q <= rem_d;
                    if (rem_d == '0) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        beats_q <= burst_of(rem_d);
                        arvalid_q <= 1'b1;
                        state_q <= S_RREQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_copy_master.sv
// tb_axi_copy_master: memory-slave bench comparing copies against a burst-split reference model
module tb_axi_copy_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [31:0] src_addr = '0, dst_addr = '0;
    logic [15:0] byte_len = '0;
    logic busy, done, err;
    logic [3:0] awid, wid, arid;
    logic [31:0] awaddr, araddr, wdata;
    logic [3:0] awlen, arlen, wstrb;
    logic [2:0] awsize, arsize;
    logic [1:0] awburst, arburst;
    logic awvalid, wlast, wvalid, bready, arvalid, rready;
    logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
    logic [1:0] bresp = '0, rresp = '0;
    logic [3:0] bid = '0, rid = '0;
    logic [31:0] rdata = '0;

    always #5 clk = ~clk;

    axi_copy_master dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .byte_len(byte_len), .busy(busy), .done(done), .err(err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int len;
        int ar_dly;
        int r_dly;
        bit stall;
        int b_err;
        int r_err;
        int exp_nb;
        bit exp_err;
    } vec_t;
    typedef struct {
        logic [31:0] addr;
        logic [3:0] len;
    } req_t;

    vec_t tbl[6];
    logic [31:0] mem [0:4095];
    logic [31:0] exp_data[$];
    req_t ar_log[$], aw_log[$], exp_req[$];
    int n_vec = 0, n_bad = 0, done_cnt = 0, cur = 0;
    int cfg_ar_dly = 0, cfg_r_dly = 0, cfg_b_err = -1, cfg_r_err = -1, exp_nb = 0;
    bit cfg_stall = 0;
    int rd_st = 0, ar_c = 0, r_c = 0, rd_beat = 0, rd_len = 0, rd_bidx = 0;
    int wr_st = 0, aw_c = 0, b_c = 0, b_lim = 0, wbeat = 0, wr_len = 0, wr_bidx = 0;
    logic [31:0] rd_addr = '0, wr_addr = '0, ar_sv_a = '0, aw_sv_a = '0, w_sv_d = '0;
    logic [3:0] ar_sv_l = '0, aw_sv_l = '0;
    bit r_hs = 0, ar_stall = 0, aw_stall = 0, w_stall = 0, w_sv_l = 0, b_pend = 0, b_last = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL v%0d %s: got %0h expected %0h", cur, name, got, exp);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial forever begin
        @(negedge clk);
        if (done) done_cnt++;
    end

    // behavioural AXI memory slave, decisions taken on the falling edge
    initial forever begin
        @(negedge clk);
        if (rst) begin
            rd_st = 0; wr_st = 0; ar_c = 0; aw_c = 0; r_hs = 0;
            ar_stall = 0; aw_stall = 0; w_stall = 0; b_pend = 0;
            arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; bvalid = 0;
        end else begin
            if (b_pend) begin
                chk("done_after_b", done, b_last);
                b_pend = 0;
            end
            if (wr_st == 3) begin
                bvalid = 0;
                wr_st = 0;
            end
            if (ar_stall) begin
                chk("ar_hold_valid", arvalid, 1);
                chk("ar_hold_addr", araddr, ar_sv_a);
                chk("ar_hold_len", arlen, ar_sv_l);
            end
            arready = 0;
            if (rd_st == 0 && arvalid) begin
                if (ar_c >= cfg_ar_dly) begin
                    arready = 1;
                    ar_log.push_back('{addr: araddr, len: arlen});
                    chk("arsize", arsize, 2);
                    chk("arburst", arburst, 1);
                    chk("arid", arid, 0);
                    rd_addr = araddr; rd_len = int'(arlen); rd_beat = 0; r_c = 0; ar_c = 0; rd_st = 1;
                end else ar_c++;
            end
            ar_stall = arvalid && !arready;
            ar_sv_a = araddr; ar_sv_l = arlen;
            if (rd_st == 1) begin
                if (r_c >= cfg_r_dly) rd_st = 2;
                else r_c++;
            end
            if (rd_st == 2) begin
                if (!rvalid || r_hs) begin
                    if (rd_beat > rd_len) begin
                        rvalid = 0; rlast = 0; rd_st = 0; rd_bidx++;
                    end else begin
                        rvalid = cfg_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                        rdata = mem[int'(rd_addr >> 2) + rd_beat];
                        rresp = (rd_bidx == cfg_r_err && rd_beat == 0) ? 2'b10 : 2'b00;
                        rlast = rd_beat == rd_len;
                    end
                end
                r_hs = rvalid && rready;
                if (r_hs) rd_beat++;
            end
            if (aw_stall) begin
                chk("aw_hold_valid", awvalid, 1);
                chk("aw_hold_addr", awaddr, aw_sv_a);
                chk("aw_hold_len", awlen, aw_sv_l);
            end
            awready = 0;
            if (wr_st == 0 && wvalid) chk("w_before_aw", wvalid, 0);
            if (wr_st == 0 && awvalid) begin
                if (aw_c >= cfg_ar_dly) begin
                    awready = 1;
                    aw_log.push_back('{addr: awaddr, len: awlen});
                    chk("awsize", awsize, 2);
                    chk("awburst", awburst, 1);
                    wr_addr = awaddr; wr_len = int'(awlen); wbeat = 0; aw_c = 0; wr_st = 1;
                end else aw_c++;
            end
            aw_stall = awvalid && !awready;
            aw_sv_a = awaddr; aw_sv_l = awlen;
            if (w_stall) begin
                chk("w_hold_valid", wvalid, 1);
                chk("w_hold_data", wdata, w_sv_d);
                chk("w_hold_last", wlast, w_sv_l);
            end
            wready = 0;
            if (wr_st == 1) begin
                wready = cfg_stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (wvalid && wready) begin
                    mem[int'(wr_addr >> 2) + wbeat] = wdata;
                    chk("wlast", wlast, wbeat == wr_len);
                    chk("wstrb", wstrb, 4'hF);
                    wbeat++;
                    if (wlast) begin
                        wr_st = 2; b_c = 0; b_lim = cfg_stall ? $urandom_range(0, 4) : 0;
                    end
                end
            end
            w_stall = wvalid && !wready;
            w_sv_d = wdata; w_sv_l = wlast;
            if (wr_st == 2) begin
                if (!bvalid) begin
                    if (b_c >= b_lim) begin
                        bvalid = 1;
                        bresp = (wr_bidx == cfg_b_err) ? 2'b10 : 2'b00;
                    end else b_c++;
                end
                if (bvalid && bready) begin
                    wr_bidx++;
                    b_pend = 1;
                    b_last = wr_bidx == exp_nb;
                    wr_st = 3;
                end
            end
        end
    end

    task automatic run_copy(input vec_t v);
        int beats, n, t, bad;
        logic [31:0] a, d;
        cfg_ar_dly = v.ar_dly; cfg_r_dly = v.r_dly; cfg_stall = v.stall;
        cfg_b_err = v.b_err; cfg_r_err = v.r_err;
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        exp_data.delete();
        for (int i = 0; i < v.len / 4; i++) exp_data.push_back(mem[int'(v.src >> 2) + i]);
        exp_req.delete();
        beats = v.len / 4; a = v.src; d = v.dst;
        while (beats > 0) begin
            n = beats > 16 ? 16 : beats;
            exp_req.push_back('{addr: a, len: 4'(n - 1)});
            exp_req.push_back('{addr: d, len: 4'(n - 1)});
            a += 32'(n * 4); d += 32'(n * 4); beats -= n;
        end
        exp_nb = exp_req.size() / 2;
        ar_log.delete(); aw_log.delete();
        rd_bidx = 0; wr_bidx = 0;
        @(negedge clk);
        done_cnt = 0;
        start = 1; src_addr = v.src; dst_addr = v.dst; byte_len = 16'(v.len);
        @(negedge clk);
        start = 0;
        chk("arvalid_latency", arvalid, 1);
        chk("busy_on", busy, 1);
        chk("err_cleared", err, 0);
        t = 0;
        while (!done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done, 1);
        @(negedge clk);
        chk("done_width", done, 0);
        chk("busy_off", busy, 0);
        chk("done_count", done_cnt, 1);
        chk("burst_count", ar_log.size(), v.exp_nb);
        chk("aw_count", aw_log.size(), v.exp_nb);
        for (int i = 0; i < exp_nb && i < ar_log.size() && i < aw_log.size(); i++) begin
            chk("araddr", ar_log[i].addr, exp_req[2 * i].addr);
            chk("arlen", ar_log[i].len, exp_req[2 * i].len);
            chk("awaddr", aw_log[i].addr, exp_req[2 * i + 1].addr);
            chk("awlen", aw_log[i].len, exp_req[2 * i + 1].len);
        end
        bad = 0;
        for (int i = 0; i < v.len / 4; i++) if (mem[int'(v.dst >> 2) + i] !== exp_data[i]) bad++;
        chk("data_words_wrong", bad, 0);
        chk("err", err, v.exp_err);
    endtask

    initial begin
        vec_t rv;
        bit saw;
        int t;
        tbl[0] = '{src: 32'h0100, dst: 32'h2000, len: 64, ar_dly: 0, r_dly: 0, stall: 0, b_err: -1, r_err: -1, exp_nb: 1, exp_err: 0};
        tbl[1] = '{src: 32'h0100, dst: 32'h2000, len: 72, ar_dly: 0, r_dly: 0, stall: 0, b_err: -1, r_err: -1, exp_nb: 2, exp_err: 0};
        tbl[2] = '{src: 32'h0400, dst: 32'h2800, len: 256, ar_dly: 5, r_dly: 50, stall: 1, b_err: -1, r_err: -1, exp_nb: 4, exp_err: 0};
        tbl[3] = '{src: 32'h0200, dst: 32'h3000, len: 128, ar_dly: 1, r_dly: 2, stall: 1, b_err: 0, r_err: -1, exp_nb: 2, exp_err: 1};
        tbl[4] = '{src: 32'h0100, dst: 32'h2000, len: 4, ar_dly: 0, r_dly: 0, stall: 0, b_err: -1, r_err: -1, exp_nb: 1, exp_err: 0};
        tbl[5] = '{src: 32'h0800, dst: 32'h3400, len: 40, ar_dly: 2, r_dly: 3, stall: 1, b_err: -1, r_err: 0, exp_nb: 1, exp_err: 1};
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valids", {arvalid, awvalid, wvalid, bready, rready}, 0);
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            cur = i;
            run_copy(tbl[i]);
        end
        for (int i = 0; i < 6; i++) begin
            cur = 10 + i;
            rv.src = 32'($urandom_range(0, 255) * 4);
            rv.dst = 32'h2000 + 32'($urandom_range(0, 255) * 4);
            rv.len = $urandom_range(1, 50) * 4;
            rv.ar_dly = $urandom_range(0, 3);
            rv.r_dly = $urandom_range(0, 5);
            rv.stall = 1;
            rv.b_err = -1;
            rv.r_err = -1;
            rv.exp_nb = (rv.len / 4 + 15) / 16;
            rv.exp_err = 0;
            run_copy(rv);
        end
        cur = 20;
        @(negedge clk);
        done_cnt = 0;
        start = 1; byte_len = 0;
        @(negedge clk);
        start = 0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            if (arvalid || awvalid || busy) saw = 1;
        end
        chk("zero_no_traffic", saw, 0);
        chk("zero_done_count", done_cnt, 1);
        cur = 21;
        cfg_stall = 1; cfg_ar_dly = 0; cfg_r_dly = 0; cfg_b_err = -1; cfg_r_err = -1; exp_nb = 1;
        @(negedge clk);
        start = 1; src_addr = 32'h0100; dst_addr = 32'h2000; byte_len = 64;
        @(negedge clk);
        start = 0;
        t = 0;
        while (!wvalid && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("reach_wdata", wvalid, 1);
        #2 rst = 1;
        #1;
        chk("rst_mid_valids", {arvalid, awvalid, wvalid, bready, rready}, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 0;
        cur = 22;
        run_copy(tbl[0]);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
